// File: rtl/somatorio_sched_if.sv
// Bundle between somatorio_sched, its N requesters and the shared somatorio
// accumulator.
//   req/ops           requester -> scheduler (request, four packed operands each)
//   done/res_*/busy   scheduler -> requester (completion pulse, result, status)
//   acc_iniciar/ent   scheduler -> accumulator
//   acc_soma/pronto/erro  accumulator -> scheduler
// Modport slave is the scheduler view; master is the client/accumulator view.
interface somatorio_sched_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]    req;
  logic [32*N-1:0] ops;
  logic [N-1:0]    done;
  logic [7:0]      res_soma;
  logic            res_erro;
  logic            res_timeout;
  logic            busy;
  logic            acc_iniciar;
  logic [7:0]      acc_ent;
  logic [7:0]      acc_soma;
  logic            acc_pronto;
  logic            acc_erro;

  modport slave (
    input  req, ops, acc_soma, acc_pronto, acc_erro,
    output done, res_soma, res_erro, res_timeout, busy, acc_iniciar, acc_ent
  );

  modport master (
    output req, ops, acc_soma, acc_pronto, acc_erro,
    input  done, res_soma, res_erro, res_timeout, busy, acc_iniciar, acc_ent
  );
endinterface

// File: rtl/somatorio_sched.sv
// Round-robin scheduler sharing one somatorio four-operand accumulator among
// N requesters. A granted requester's operands are latched, streamed to the
// accumulator (iniciar + op0, then op1..op3), and the answer (or a timeout)
// is returned with a one-cycle one-hot done pulse.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-low
//   bus    somatorio_sched_if.slave (requester side and accumulator side)
module somatorio_sched #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  somatorio_sched_if.slave  bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_ISSUE1,
    S_ISSUE2,
    S_ISSUE3,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [31:0]     r_ops;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_done;
  logic [7:0]      r_res_soma;
  logic            r_res_erro;
  logic            r_res_timeout;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_cand;
  logic            w_iniciar;
  logic [7:0]      w_ent;
  logic [N-1:0]    w_onehot;

  // First pending requester at or after r_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IW'((32'(r_ptr) + k) % N);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << r_idx;

  // Scheduler state machine; result and done are captured on leaving WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_ops         <= '0;
      r_cnt         <= '0;
      r_done        <= '0;
      r_res_soma    <= '0;
      r_res_erro    <= 1'b0;
      r_res_timeout <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_idx   <= w_pick;
            r_ops   <= bus.ops[32*w_pick +: 32];
            r_state <= S_ISSUE0;
          end
        end
        S_ISSUE0: r_state <= S_ISSUE1;
        S_ISSUE1: r_state <= S_ISSUE2;
        S_ISSUE2: r_state <= S_ISSUE3;
        S_ISSUE3: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // erro outranks pronto when both arrive together
          if (bus.acc_erro) begin
            r_res_soma    <= bus.acc_soma;
            r_res_erro    <= 1'b1;
            r_res_timeout <= 1'b0;
            r_done        <= w_onehot;
            r_state       <= S_DONE;
          end else if (bus.acc_pronto) begin
            r_res_soma    <= bus.acc_soma;
            r_res_erro    <= 1'b0;
            r_res_timeout <= 1'b0;
            r_done        <= w_onehot;
            r_state       <= S_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_res_soma    <= '0;
            r_res_erro    <= 1'b0;
            r_res_timeout <= 1'b1;
            r_done        <= w_onehot;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_ptr   <= (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Accumulator drive decoded from the registered state and latched operands.
  always_comb begin
    w_iniciar = 1'b0;
    w_ent     = '0;
    case (r_state)
      S_ISSUE0: begin
        w_iniciar = 1'b1;
        w_ent     = r_ops[7:0];
      end
      S_ISSUE1: w_ent = r_ops[15:8];
      S_ISSUE2: w_ent = r_ops[23:16];
      S_ISSUE3: w_ent = r_ops[31:24];
      default:  w_ent = '0;
    endcase
  end

  assign bus.acc_iniciar = w_iniciar;
  assign bus.acc_ent     = w_ent;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.res_soma    = r_res_soma;
  assign bus.res_erro    = r_res_erro;
  assign bus.res_timeout = r_res_timeout;

endmodule
